// File: rtl/conveyor_writeback.sv
// conveyor_writeback: reserves conveyor slots at dispatch and writes pipeline results back into them.
module conveyor_writeback #(
  parameter int WORD_WIDTH = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int FAULT_ADDR_WIDTH = 3,
  parameter int PIPELINES = 2,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(PIPELINES),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic reserve_valid,
  input  logic [PW-1:0] reserve_pipe,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] reserve_slot,
  input  logic reserve_conveyor,
  output logic halt,
  input  logic [PIPELINES-1:0] result_valid,
  input  logic [PIPELINES*WORD_WIDTH-1:0] result_value,
  input  logic [PIPELINES*FAULT_ADDR_WIDTH-1:0] result_fault,
  output logic [PIPELINES-1:0] result_ready,
  output logic wr_en,
  output logic wr_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] wr_addr,
  output logic [FAULT_ADDR_WIDTH+WORD_WIDTH:0] wr_data,
  output logic [PIPELINES*CW-1:0] outstanding,
  output logic orphan
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = 1 + CONVEYOR_ADDR_WIDTH;
  logic [TW-1:0] tags [PIPELINES][DEPTH];
  logic [AW-1:0] rd_ptr [PIPELINES];
  logic [AW-1:0] wr_ptr [PIPELINES];
  logic [CW-1:0] count [PIPELINES];
  logic [PIPELINES-1:0] eligible, empty;
  logic [PW-1:0] rr_ptr, grant_pipe, rr_next;
  logic grant_any, accept;
  logic [TW-1:0] head;
  for (genvar p = 0; p < PIPELINES; p++) begin : g_pipe
    assign empty[p] = count[p] == '0;
    assign eligible[p] = result_valid[p] & !empty[p] & !reserve_valid & !flush;
    assign outstanding[p*CW +: CW] = count[p];
  end
  assign accept = reserve_valid & !flush & (count[reserve_pipe] < CW'(DEPTH));
  assign halt = reserve_valid & !flush & (count[reserve_pipe] == CW'(DEPTH));
  // First eligible pipeline at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_pipe = rr_ptr;
    for (int i = 0; i < PIPELINES; i++) begin
      if (!grant_any && eligible[(int'(rr_ptr) + i) % PIPELINES]) begin
        grant_any = 1'b1;
        grant_pipe = PW'((int'(rr_ptr) + i) % PIPELINES);
      end
    end
  end
  assign rr_next = PW'((int'(grant_pipe) + 1) % PIPELINES);
  assign result_ready = grant_any ? PIPELINES'(1) << grant_pipe : '0;
  assign head = tags[grant_pipe][rd_ptr[grant_pipe]];
  always_ff @(posedge clk) begin
    for (int p = 0; p < PIPELINES; p++) begin
      if (reset || flush) begin
        count[p] <= '0;
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
      end else if (accept && reserve_pipe == PW'(p)) begin
        tags[p][wr_ptr[p]] <= {reserve_conveyor, reserve_slot};
        wr_ptr[p] <= wr_ptr[p] + 1'b1;
        count[p] <= count[p] + 1'b1;
      end else if (grant_any && grant_pipe == PW'(p)) begin
        rd_ptr[p] <= rd_ptr[p] + 1'b1;
        count[p] <= count[p] - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (grant_any) rr_ptr <= rr_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en <= 1'b0;
      wr_conveyor <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      orphan <= 1'b0;
    end else begin
      wr_en <= accept | grant_any;
      orphan <= |(result_valid & empty);
      if (accept) begin
        wr_conveyor <= reserve_conveyor;
        wr_addr <= reserve_slot;
        wr_data <= '0;
      end else if (grant_any) begin
        {wr_conveyor, wr_addr} <= head;
        wr_data <= {1'b1, result_fault[int'(grant_pipe)*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH],
                    result_value[int'(grant_pipe)*WORD_WIDTH +: WORD_WIDTH]};
      end
    end
  end
endmodule

// File: tb/tb_conveyor_writeback.sv
// tb_conveyor_writeback: directed and random stimulus against a queue-based reference model.
module tb_conveyor_writeback;
  logic clk = 0, rst = 0, fl = 0, rv = 0, rpipe = 0, rconv = 0;
  logic [3:0] rslot = 0;
  logic [1:0] res_v = 0;
  logic [63:0] res_val = 0;
  logic [5:0] res_flt = 0;
  logic halt, wr_en, wr_conveyor, orphan;
  logic [1:0] result_ready;
  logic [3:0] wr_addr;
  logic [35:0] wr_data;
  logic [5:0] outstanding;
  int vectors = 0, miscompares = 0;
  logic [4:0] q [2][$];
  int rr = 0;
  logic e_en = 0, e_conv = 0, e_orph = 0;
  logic [3:0] e_addr = 0;
  logic [35:0] e_data = 0;
  logic [31:0] v;

  conveyor_writeback dut (
    .clk(clk), .reset(rst), .flush(fl), .reserve_valid(rv), .reserve_pipe(rpipe),
    .reserve_slot(rslot), .reserve_conveyor(rconv), .halt(halt), .result_valid(res_v),
    .result_value(res_val), .result_fault(res_flt), .result_ready(result_ready),
    .wr_en(wr_en), .wr_conveyor(wr_conveyor), .wr_addr(wr_addr), .wr_data(wr_data),
    .outstanding(outstanding), .orphan(orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the model, check combinational outputs, clock, check registered outputs.
  task automatic cycle();
    int g;
    bit acc, eo;
    logic [1:0] er;
    logic [4:0] t;
    g = -1;
    acc = rv && !fl && q[rpipe].size() < 4;
    for (int i = 0; i < 2; i++)
      if (g < 0 && res_v[(rr + i) % 2] && q[(rr + i) % 2].size() > 0 && !rv && !fl) g = (rr + i) % 2;
    er = (g >= 0) ? 2'(1 << g) : 2'b00;
    eo = (res_v[0] && q[0].size() == 0) || (res_v[1] && q[1].size() == 0);
    #1;
    if (!rst) begin
      chk("halt", halt, rv && !fl && q[rpipe].size() == 4);
      chk("result_ready", result_ready, er);
    end
    if (rst) begin
      q[0].delete(); q[1].delete(); rr = 0;
      e_en = 0; e_conv = 0; e_addr = 0; e_data = 0; e_orph = 0;
    end else begin
      e_orph = eo;
      if (fl) begin
        q[0].delete(); q[1].delete(); e_en = 0;
      end else if (acc) begin
        q[rpipe].push_back({rconv, rslot});
        e_en = 1; e_conv = rconv; e_addr = rslot; e_data = 0;
      end else if (g >= 0) begin
        t = q[g].pop_front();
        e_en = 1; {e_conv, e_addr} = t;
        e_data = {1'b1, res_flt[g*3 +: 3], res_val[g*32 +: 32]};
        rr = (g + 1) % 2;
      end else e_en = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("wr_en", wr_en, e_en);
    chk("wr_conveyor", wr_conveyor, e_conv);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("orphan", orphan, e_orph);
    chk("outstanding", outstanding, {3'(q[1].size()), 3'(q[0].size())});
  endtask

  initial begin
    rst = 1;
    cycle(); cycle();
    rst = 0;
    chk("reset wr_en", wr_en, 0);
    chk("reset wr_data", wr_data, 0);
    chk("reset outstanding", outstanding, 0);
    // Basic reservation then result on pipe 0
    rv = 1; rpipe = 0; rslot = 4'hF; rconv = 0;
    cycle();
    rv = 0;
    chk("resv addr", wr_addr, 4'hF);
    chk("resv data", wr_data, 0);
    res_v = 2'b01; res_val = 64'h0_1234_5678; res_flt = 0;
    #1 chk("ready p0", result_ready, 2'b01);
    cycle();
    res_v = 0;
    chk("result data", wr_data, {1'b1, 3'd0, 32'h1234_5678});
    chk("result addr", wr_addr, 4'hF);
    // Fill pipe 1, overflow, drain in order
    rpipe = 1;
    for (int k = 3; k >= 0; k--) begin
      rv = 1; rslot = 4'(k);
      cycle();
    end
    rslot = 4'h9;
    cycle();
    chk("halt full", halt, 1);
    chk("no write on halt", wr_en, 0);
    rv = 0;
    for (int k = 3; k >= 0; k--) begin
      res_v = 2'b10; res_val = {$urandom, $urandom};
      cycle();
      chk("drain addr", wr_addr, 4'(k));
    end
    res_v = 0;
    chk("outstanding drained", outstanding[5:3], 0);
    // Round robin with reservation blocking
    rv = 1; rpipe = 0; rslot = 5; cycle();
    rpipe = 1; rslot = 6; cycle();
    rpipe = 0; rslot = 7; res_v = 2'b11; res_val = {$urandom, $urandom};
    cycle();
    rv = 0;
    cycle();
    chk("rr first", wr_addr, 5);
    cycle();
    chk("rr second", wr_addr, 6);
    res_v = 2'b01; cycle();
    res_v = 0;
    // Orphan
    res_v = 2'b10; cycle();
    chk("orphan pulse", orphan, 1);
    chk("orphan no write", wr_en, 0);
    res_v = 0; cycle();
    chk("orphan clear", orphan, 0);
    // Flush
    rv = 1; rpipe = 0; rslot = 1; cycle(); rslot = 2; cycle();
    rv = 0; fl = 1; cycle();
    fl = 0;
    chk("flush wr_en", wr_en, 0);
    chk("flush counts", outstanding, 0);
    res_v = 2'b01; cycle();
    res_v = 0;
    chk("orphan after flush", orphan, 1);
    // Interrupt conveyor with fault, then reset mid-stream
    rv = 1; rpipe = 0; rconv = 1; rslot = 4'hE; cycle();
    rv = 0; rconv = 0; v = $urandom;
    res_v = 2'b01; res_val = {32'h0, v}; res_flt = 6'd3; cycle();
    res_v = 0;
    chk("irq conv", wr_conveyor, 1);
    chk("irq addr", wr_addr, 4'hE);
    chk("irq data", wr_data, {1'b1, 3'd3, v});
    rv = 1; rpipe = 1; rslot = 8; cycle();
    rv = 0; rst = 1; res_v = 2'b10; cycle();
    rst = 0; res_v = 0;
    chk("reset mid wr_en", wr_en, 0);
    chk("reset mid counts", outstanding, 0);
    cycle();
    chk("reset after wr_en", wr_en, 0);
    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rv = ($urandom % 3) == 0;
      rpipe = 1'($urandom);
      rslot = 4'($urandom);
      rconv = 1'($urandom);
      res_v = 2'($urandom);
      res_val = {$urandom, $urandom};
      res_flt = 6'($urandom);
      fl = ($urandom % 30) == 0;
      rst = ($urandom % 120) == 0;
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
